// File: rtl/cpu_req_gen_pkg.sv
// Shared definitions for the CPU request generator: default widths, sweep
// mode encodings, generator state encodings and a saturating counter helper.
package cpu_req_gen_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MODE_WR    = 2'd0,
    MODE_RDCHK = 2'd1,
    MODE_WRRD  = 2'd2,
    MODE_RD    = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_RESP = 3'd2,
    ST_NEXT      = 3'd3,
    ST_FIN       = 3'd4
  } gen_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cpu_req_gen_addr_seq.sv
// Sweep address sequencer: holds the op index, current address and the
// write/read phase of a write-then-readback pair.
module cpu_req_gen_addr_seq
  import cpu_req_gen_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic              pair_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [15:0]       num_ops,
  output logic [ADDR_W-1:0] addr,
  output logic              phase_rd,
  output logic              last_op
);

  logic [ADDR_W-1:0] stride_q;
  logic [15:0]       num_ops_q;
  logic [15:0]       idx;
  logic              pair_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      stride_q  <= '0;
      num_ops_q <= '0;
      idx       <= '0;
      phase_rd  <= 1'b0;
      pair_q    <= 1'b0;
    end else if (load) begin
      addr      <= base_addr;
      stride_q  <= stride;
      num_ops_q <= num_ops;
      idx       <= '0;
      phase_rd  <= 1'b0;
      pair_q    <= pair_mode;
    end else if (advance) begin
      if (pair_q && !phase_rd) begin
        phase_rd <= 1'b1;
      end else begin
        // address wraps naturally modulo 2^ADDR_W
        phase_rd <= 1'b0;
        idx      <= idx + 16'd1;
        addr     <= addr + stride_q;
      end
    end
  end

  // True while the op just completed is the final one of the sweep.
  assign last_op = (!pair_q || phase_rd) && (idx == num_ops_q - 16'd1);

endmodule

// File: rtl/cpu_req_gen.sv
// CPU-side request generator replaying programmed access sweeps into the cache.
// Optional min/max latency and total cycle stats under CPU_REQ_GEN_LAT_STATS_EN.
//
// state        | meaning
// IDLE         | waiting for start
// ISSUE        | cpu_req held until accepted
// WAIT_RESP    | accepted, counting latency until cpu_resp
// NEXT         | advance phase or address, decide if sweep is over
// FIN          | one-cycle done pulse
module cpu_req_gen
  import cpu_req_gen_pkg::*;
#(
  parameter int          ADDR_W  = ADDR_WIDTH,
  parameter int          DATA_W  = DATA_WIDTH,
  parameter logic [31:0] SEED    = 32'hA5A5_0000,
  parameter int          TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   stride,
  input  logic [15:0]         num_ops,
  output logic                busy,
  output logic                done,
  output logic [15:0]         err_count,
  output logic [15:0]         last_latency,
  output logic                cpu_req,
  output logic                cpu_rw,
  output logic [ADDR_W-1:0]   cpu_addr,
  output logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W/8-1:0] cpu_wstrb,
  input  logic                cpu_ready,
  input  logic                cpu_resp,
  input  logic [DATA_W-1:0]   cpu_rdata
`ifdef CPU_REQ_GEN_LAT_STATS_EN
  ,
  output logic [15:0]         min_latency,
  output logic [15:0]         max_latency,
  output logic [31:0]         total_cycles
`endif
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  gen_state_e        state, state_nx;
  mode_e             mode_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              phase_rd, last_op;
  logic              seq_load, seq_advance;
  logic [WD_W-1:0]   wd_cnt;
  logic [15:0]       lat_cnt;
  logic              is_write, check_read, wd_expired, in_op;
  logic [DATA_W-1:0] pattern;

  cpu_req_gen_addr_seq #(.ADDR_W(ADDR_W)) u_addr_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (seq_load),
    .advance   (seq_advance),
    .pair_mode (mode == MODE_WRRD),
    .base_addr (base_addr),
    .stride    (stride),
    .num_ops   (num_ops),
    .addr      (cur_addr),
    .phase_rd  (phase_rd),
    .last_op   (last_op)
  );

  assign is_write   = (mode_q == MODE_WR) || ((mode_q == MODE_WRRD) && !phase_rd);
  assign check_read = !is_write && ((mode_q == MODE_RDCHK) || (mode_q == MODE_WRRD));
  assign pattern    = DATA_W'(cur_addr) ^ DATA_W'(SEED);
  assign wd_expired = (wd_cnt == '0);
  assign in_op      = (state == ST_ISSUE) || (state == ST_WAIT_RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    seq_load    = 1'b0;
    seq_advance = 1'b0;
    busy        = (state != ST_IDLE);
    done        = 1'b0;
    cpu_req     = 1'b0;
    cpu_rw      = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    cpu_wstrb   = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          seq_load = 1'b1;
          state_nx = (num_ops == 16'd0) ? ST_FIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cpu_req   = 1'b1;
        cpu_rw    = is_write;
        cpu_addr  = cur_addr;
        cpu_wdata = is_write ? pattern : '0;
        cpu_wstrb = is_write ? '1 : '0;
        if (wd_expired)     state_nx = ST_NEXT;
        else if (cpu_ready) state_nx = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        if (cpu_resp || wd_expired) state_nx = ST_NEXT;
      end
      ST_NEXT: begin
        seq_advance = 1'b1;
        state_nx    = last_op ? ST_FIN : ST_ISSUE;
      end
      ST_FIN: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Watchdog is a down-counter reloaded for every op, including readback phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q       <= MODE_WR;
      wd_cnt       <= '0;
      lat_cnt      <= '0;
      err_count    <= '0;
      last_latency <= '0;
    end else begin
      if (state == ST_IDLE && start) begin
        mode_q    <= mode_e'(mode);
        err_count <= '0;
      end
      if (state_nx == ST_ISSUE && state != ST_ISSUE)
        wd_cnt <= WD_W'(TIMEOUT - 1);
      else if (in_op && !wd_expired)
        wd_cnt <= wd_cnt - 1'b1;
      if (state == ST_ISSUE)
        lat_cnt <= 16'd1;
      else if (state == ST_WAIT_RESP)
        lat_cnt <= lat_cnt + 16'd1;
      if (state == ST_WAIT_RESP && cpu_resp) begin
        last_latency <= lat_cnt;
        if (check_read && (cpu_rdata != pattern))
          err_count <= sat_inc16(err_count);
      end else if (in_op && wd_expired) begin
        err_count <= sat_inc16(err_count);
      end
    end
  end

`ifdef CPU_REQ_GEN_LAT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      min_latency  <= '0;
      max_latency  <= '0;
      total_cycles <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        min_latency  <= 16'hFFFF;
        max_latency  <= '0;
        total_cycles <= 32'd1;
      end
    end else begin
      total_cycles <= total_cycles + 32'd1;
      // timed-out ops never see cpu_resp here, so they stay out of min/max
      if (state == ST_WAIT_RESP && cpu_resp) begin
        if (lat_cnt < min_latency) min_latency <= lat_cnt;
        if (lat_cnt > max_latency) max_latency <= lat_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_req_gen.sv
// Self-checking bench for cpu_req_gen: a responder with a memory model, an
// expected-request queue built from the sweep rules, and directed sweeps.
module tb_cpu_req_gen;

  localparam logic [31:0] SEED = 32'hA5A5_0000;

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk, rst, start;
  logic [1:0]  mode;
  logic [31:0] base_addr, stride;
  logic [15:0] num_ops;
  logic        busy, done;
  logic [15:0] err_count, last_latency;
  logic        cpu_req, cpu_rw;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_ready, cpu_resp;
  logic [31:0] cpu_rdata;

  int chk_cnt = 0;
  int pass_cnt = 0;

  req_t        exp_q[$];
  logic [31:0] acc_addr[$];
  logic [31:0] acc_wdata[$];
  logic [31:0] mem[logic [31:0]];
  int          resp_cnt = 0;
  int          resp_delay = 3;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          done_cnt = 0;
  logic        no_resp = 1'b0;
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;
  logic [31:0] rsp_data = 32'h0;

  cpu_req_gen #(
    .ADDR_W(32), .DATA_W(32), .SEED(SEED), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .base_addr(base_addr), .stride(stride), .num_ops(num_ops),
    .busy(busy), .done(done), .err_count(err_count), .last_latency(last_latency),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_ready(cpu_ready), .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] resp_val(input logic [31:0] a);
    if (corrupt_en && a == corrupt_addr) return 32'hDEADBEEF;
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Responder and per-cycle compare of the live request against the model queue.
  initial begin
    cpu_ready = 1'b0;
    cpu_resp  = 1'b0;
    cpu_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_cnt  = 0;
        exp_q.delete();
        cpu_ready = 1'b0;
        cpu_resp  = 1'b0;
        cpu_rdata = '0;
      end else begin
        cpu_resp  = 1'b0;
        cpu_rdata = '0;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0 && !no_resp) begin
            cpu_resp  = 1'b1;
            cpu_rdata = rsp_data;
          end
        end
        if (done) done_cnt++;
        cpu_ready = 1'b0;
        if (cpu_req) begin
          chk("req_expected", 128'(exp_q.size() != 0), 128'(1));
          if (exp_q.size() != 0)
            chk("req_fields", {cpu_rw, cpu_addr, cpu_wdata, cpu_wstrb}, exp_q[0]);
          if (stall_left > 0) begin
            stall_left--;
            stall_seen++;
          end else begin
            cpu_ready = 1'b1;
            acc_addr.push_back(cpu_addr);
            acc_wdata.push_back(cpu_wdata);
            if (cpu_rw) mem[cpu_addr] = cpu_wdata;
            rsp_data = resp_val(cpu_addr);
            resp_cnt = resp_delay;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic run_sweep(input string name, input logic [1:0] m, input logic [31:0] base,
                           input logic [31:0] str, input logic [15:0] n,
                           input int lit_err, input int lit_lat);
    logic [31:0] shadow[logic [31:0]];
    logic [31:0] a, rd;
    int exp_err, n_req, acc0, done0, cyc;
    shadow = mem;
    exp_err = 0;
    exp_q.delete();
    a = base;
    for (int i = 0; i < int'(n); i++) begin
      if (m == 2'd0 || m == 2'd2) begin
        exp_q.push_back('{1'b1, a, a ^ SEED, 4'hF});
        shadow[a] = a ^ SEED;
        if (no_resp) exp_err++;
      end
      if (m != 2'd0) begin
        exp_q.push_back('{1'b0, a, 32'h0, 4'h0});
        rd = (corrupt_en && a == corrupt_addr) ? 32'hDEADBEEF :
             (shadow.exists(a) ? shadow[a] : 32'h0);
        if (no_resp) exp_err++;
        else if (m != 2'd3 && rd != (a ^ SEED)) exp_err++;
      end
      a = a + str;
    end
    n_req = exp_q.size();
    acc0  = acc_addr.size();
    done0 = done_cnt;
    @(negedge clk);
    mode = m; base_addr = base; stride = str; num_ops = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, 128'(busy), 128'(1));
    cyc = 0;
    while (done_cnt == done0 && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done_seen"}, 128'(cyc < 600), 128'(1));
    chk({name, "_accepts"}, 128'(acc_addr.size() - acc0), 128'(n_req));
    chk({name, "_err_model"}, 128'(exp_err), 128'(lit_err));
    chk({name, "_err"}, 128'(err_count), 128'(exp_err));
    if (lit_lat >= 0) chk({name, "_latency"}, 128'(last_latency), 128'(lit_lat));
    @(negedge clk);
    chk({name, "_idle"}, 128'({busy, done}), 128'(0));
  endtask

  initial begin
    int a0, cyc;
    rst = 1'b1; start = 1'b0; mode = '0; base_addr = '0; stride = '0; num_ops = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cpu_req, cpu_rw, cpu_addr, cpu_wdata, cpu_wstrb, busy, done,
                          err_count, last_latency}, '0);
    rst = 1'b0;
    @(negedge clk);

    a0 = acc_addr.size();
    run_sweep("wr_sweep", 2'd0, 32'h100, 32'd4, 16'd4, 0, 3);
    chk("wr_first_addr", 128'(acc_addr[a0]), 128'(32'h100));
    chk("wr_first_data", 128'(acc_wdata[a0]), 128'(32'hA5A50100));
    chk("wr_last_data", 128'(acc_wdata[a0+3]), 128'(32'hA5A5010C));

    a0 = acc_addr.size();
    run_sweep("wrrd", 2'd2, 32'h100, 32'd4, 16'd4, 0, 3);
    chk("wrrd_pair_addr", 128'(acc_addr[a0+1]), 128'(32'h100));

    corrupt_en = 1'b1; corrupt_addr = 32'h108;
    run_sweep("mismatch", 2'd1, 32'h100, 32'd4, 16'd4, 1, 3);
    corrupt_en = 1'b0;

    stall_seen = 0; stall_left = 5;
    run_sweep("stall", 2'd0, 32'h200, 32'd4, 16'd1, 0, 3);
    chk("stall_cycles", 128'(stall_seen), 128'(5));

    no_resp = 1'b1;
    run_sweep("timeout", 2'd1, 32'h100, 32'd4, 16'd2, 2, -1);
    no_resp = 1'b0;

    a0 = acc_addr.size();
    run_sweep("wrap", 2'd0, 32'hFFFF_FFFC, 32'd8, 16'd2, 0, 3);
    chk("wrap_addr", 128'(acc_addr[a0+1]), 128'(32'h4));

    run_sweep("zero_ops", 2'd0, 32'h100, 32'd4, 16'd0, 0, -1);

    resp_delay = 10;
    exp_q.delete();
    exp_q.push_back('{1'b0, 32'h300, 32'h0, 4'h0});
    a0 = acc_addr.size();
    @(negedge clk);
    mode = 2'd3; base_addr = 32'h300; stride = 32'd4; num_ops = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (acc_addr.size() == a0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_accept_seen", 128'(cyc < 50), 128'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_op_outputs", {cpu_req, cpu_rw, cpu_addr, cpu_wdata, cpu_wstrb, busy, done,
                               err_count, last_latency}, '0);
    rst = 1'b0;
    resp_delay = 3;
    repeat (12) @(negedge clk);
    chk("rst_stays_idle", 128'({cpu_req, busy, last_latency}), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
